prbs15_gen: RTL



---
 rtl/prbs15_gen_if.sv | 27 ++
 rtl/prbs15_gen.sv | 104 ++++++++++
 2 files changed

// File: rtl/prbs15_gen_if.sv
// Data/flag bundle between the pattern detector feed and the PRBS-15 generator.
// The generator attaches as slave; whoever drives InData/Flag uses master.
interface prbs15_gen_if #(
  parameter int BusWidth = 8
);
  logic [BusWidth-1:0] InData;
  logic                Flag;
  logic [BusWidth-1:0] OutData;
  logic                PrbsValid;
  logic                Busy;

  modport master (
    output InData,
    output Flag,
    input  OutData,
    input  PrbsValid,
    input  Busy
  );

  modport slave (
    input  InData,
    input  Flag,
    output OutData,
    output PrbsValid,
    output Busy
  );
endinterface

// File: rtl/prbs15_gen.sv
// Byte-wide PRBS-15 (x^15 + x^14 + 1) burst generator: registered pass-through while idle,
// one reseeded burst of PrbsLen words per Flag assertion, then waits for Flag to drop.
module prbs15_gen #(
  parameter int          BusWidth = 8,
  parameter logic [14:0] Seed     = 15'h7FFF,
  parameter int          PrbsLen  = 32,
  parameter int          CntWidth = 8
) (
  input  logic          CLK,
  input  logic          RST,
  prbs15_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGen     = 2'd1,
    StRelease = 2'd2
  } state_e;

  // An all-zero seed would lock the LFSR, so it is replaced by all ones.
  localparam logic [14:0]         SeedEff = (Seed == 15'd0) ? 15'h7FFF : Seed;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(PrbsLen - 1);

  state_e                state_q, state_d;
  logic [14:0]           lfsr_q, lfsr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [BusWidth-1:0]   outData_q, outData_d;
  logic                  prbsValid_q, prbsValid_d;

  logic [14:0]           lfsrStep;
  logic [BusWidth-1:0]   prbsWord;

  // BusWidth LFSR steps per clock; the first bit out lands in the MSB.
  always_comb begin
    lfsrStep = lfsr_q;
    prbsWord = '0;
    for (int i = BusWidth - 1; i >= 0; i--) begin
      prbsWord[i] = lfsrStep[14];
      lfsrStep    = {lfsrStep[13:0], lfsrStep[14] ^ lfsrStep[13]};
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    outData_d   = bus.InData;
    prbsValid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Flag) begin
          state_d = StGen;
          lfsr_d  = SeedEff;
          cnt_d   = '0;
        end
      end

      // Flag is deliberately ignored until the last word so a burst always completes.
      StGen: begin
        outData_d   = prbsWord;
        prbsValid_d = 1'b1;
        lfsr_d      = lfsrStep;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = bus.Flag ? StRelease : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRelease: begin
        if (!bus.Flag) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      lfsr_q      <= SeedEff;
      cnt_q       <= '0;
      outData_q   <= '0;
      prbsValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      outData_q   <= outData_d;
      prbsValid_q <= prbsValid_d;
    end
  end

  assign bus.OutData   = outData_q;
  assign bus.PrbsValid = prbsValid_q;
  assign bus.Busy      = (state_q != StIdle);

endmodule
